// File: rtl/tnn_vote_pkg.sv
// Shared types and sizing for the ternary-NN vote/argmax block.
package tnn_vote_pkg;

    localparam int unsigned NUM_CLASSES = 7;
    localparam int unsigned CLS_W       = 3;
    localparam int unsigned CNT_W       = 5;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        OUT   = 2'd2
    } vote_state_t;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/tnn_vote_argmax_if.sv
// Decision-in / result-out handshake bundle for tnn_vote_argmax.
// Optional margin output is present when TNN_VOTE_MARGIN_EN is defined.
interface tnn_vote_argmax_if;
    import tnn_vote_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic [CLS_W-1:0] in_class;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [CLS_W-1:0] out_class;
    cnt_t             out_votes;
    logic             err_class;
`ifdef TNN_VOTE_MARGIN_EN
    cnt_t             out_margin;
`endif

    // Upstream/downstream side driving decisions and consuming results.
    modport master (
        output in_valid, in_bit, in_class, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_votes, err_class
`ifdef TNN_VOTE_MARGIN_EN
        , input out_margin
`endif
    );

    // Voting block side.
    modport slave (
        input  in_valid, in_bit, in_class, in_last, out_ready,
        output in_ready, out_valid, out_class, out_votes, err_class
`ifdef TNN_VOTE_MARGIN_EN
        , output out_margin
`endif
    );

endinterface

// File: rtl/tnn_vote_counter_bank.sv
// Per-class saturating vote counters with synchronous clear and a read mux.
module tnn_vote_counter_bank
    import tnn_vote_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en_i,
    input  logic [CLS_W-1:0] inc_cls_i,
    input  logic             clr_i,
    input  logic [CLS_W-1:0] rd_idx_i,
    output cnt_t             rd_cnt_c_o
);

    localparam cnt_t CNT_MAX = '1;

    cnt_t cnt_q [NUM_CLASSES];
    cnt_t cnt_d [NUM_CLASSES];

    // Next count: clear wins, otherwise saturating increment of the selected class.
    always_comb begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_i) begin
                cnt_d[i] = '0;
            end else if (inc_en_i && (inc_cls_i == CLS_W'(i)) && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Counter storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Read mux for the scan index.
    always_comb begin
        rd_cnt_c_o = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (rd_idx_i == CLS_W'(i)) rd_cnt_c_o = cnt_q[i];
        end
    end

endmodule

// File: rtl/tnn_vote_argmax.sv
// Counts per-class 1-decisions over a frame, then scans for the winning class.
// Optional TNN_VOTE_MARGIN_EN adds a runner-up tracker and out_margin.
module tnn_vote_argmax
    import tnn_vote_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    tnn_vote_argmax_if.slave   bus
);

    vote_state_t      state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CLS_W-1:0] idx_q;
    logic [CLS_W-1:0] best_cls_q;
    cnt_t             best_cnt_q;
    logic [CLS_W-1:0] out_class_q;
    cnt_t             out_votes_q;
    logic             err_class_q;

    logic             accept_c;
    logic             cls_ok_c;
    logic             last_idx_c;
    logic             handshake_c;
    logic             take_c;
    cnt_t             rd_cnt_c;
    logic [CLS_W-1:0] scan_cls_c;
    cnt_t             scan_cnt_c;

    assign accept_c    = bus.in_valid & in_ready_q;
    assign cls_ok_c    = {1'b0, bus.in_class} < (CLS_W+1)'(NUM_CLASSES);
    assign last_idx_c  = idx_q == CLS_W'(NUM_CLASSES - 1);
    assign handshake_c = out_valid_q & bus.out_ready;

    tnn_vote_counter_bank u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_en_i   (accept_c & bus.in_bit & cls_ok_c),
        .inc_cls_i  (bus.in_class),
        .clr_i      (handshake_c),
        .rd_idx_i   (idx_q),
        .rd_cnt_c_o (rd_cnt_c)
    );

    // Strictly-greater compare keeps ties on the lowest index.
    assign take_c     = rd_cnt_c > best_cnt_q;
    assign scan_cls_c = take_c ? idx_q : best_cls_q;
    assign scan_cnt_c = take_c ? rd_cnt_c : best_cnt_q;

`ifdef TNN_VOTE_MARGIN_EN
    cnt_t sec_cnt_q;
    cnt_t sec_cnt_c;
    cnt_t out_margin_q;

    // Runner-up tracker: a displaced leader or a new tie becomes second.
    always_comb begin
        sec_cnt_c = sec_cnt_q;
        if (take_c)                     sec_cnt_c = best_cnt_q;
        else if (rd_cnt_c > sec_cnt_q)  sec_cnt_c = rd_cnt_c;
    end

    // Runner-up and margin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_q    <= '0;
            out_margin_q <= '0;
        end else if (state_q == ACCUM) begin
            if (accept_c && bus.in_last) sec_cnt_q <= '0;
        end else if (state_q == SCAN) begin
            sec_cnt_q <= sec_cnt_c;
            if (last_idx_c) out_margin_q <= scan_cnt_c - sec_cnt_c;
        end
    end

    assign bus.out_margin = out_margin_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept_c && bus.in_last) state_d = SCAN;
            SCAN:    if (last_idx_c)              state_d = OUT;
            OUT:     if (handshake_c)             state_d = ACCUM;
            default:                              state_d = ACCUM;
        endcase
    end

    // Handshake outputs decoded from the upcoming state, then registered.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        if (state_d == ACCUM) in_ready_d  = 1'b1;
        if (state_d == OUT)   out_valid_d = 1'b1;
    end

    // Handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Scan tracker, result registers and sticky bad-class flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            best_cls_q  <= '0;
            best_cnt_q  <= '0;
            out_class_q <= '0;
            out_votes_q <= '0;
            err_class_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept_c && !cls_ok_c) err_class_q <= 1'b1;
                    if (accept_c && bus.in_last) begin
                        idx_q      <= '0;
                        best_cls_q <= '0;
                        best_cnt_q <= '0;
                    end
                end
                SCAN: begin
                    idx_q      <= idx_q + CLS_W'(1);
                    best_cls_q <= scan_cls_c;
                    best_cnt_q <= scan_cnt_c;
                    if (last_idx_c) begin
                        out_class_q <= scan_cls_c;
                        out_votes_q <= scan_cnt_c;
                    end
                end
                OUT: begin
                    if (handshake_c) err_class_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_votes = out_votes_q;
    assign bus.err_class = err_class_q;

endmodule
